// File: rtl/csr_trap_unit_pkg.sv
// Shared definitions for the machine-mode CSR / trap unit: CSR addresses,
// reset values, cause codes, mstatus bit positions and CSR op encodings.
package csr_trap_unit_pkg;

    // CSR addresses
    localparam logic [11:0] CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_MISA      = 12'h301;
    localparam logic [11:0] CSR_MIE       = 12'h304;
    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MCAUSE    = 12'h342;
    localparam logic [11:0] CSR_MTVAL     = 12'h343;
    localparam logic [11:0] CSR_MIP       = 12'h344;
    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
    localparam logic [11:0] CSR_CYCLE     = 12'hC00;
    localparam logic [11:0] CSR_INSTRET   = 12'hC02;
    localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
    localparam logic [11:0] CSR_INSTRETH  = 12'hC82;
    localparam logic [11:0] CSR_MHARTID   = 12'hF14;

    // mstatus: MPP is hard-wired to machine mode (bits 12:11 = 11)
    localparam logic [31:0] MSTATUS_RST      = 32'h0000_1800;
    localparam int          MSTATUS_MIE_BIT  = 3;
    localparam int          MSTATUS_MPIE_BIT = 7;

    // Standard interrupt enable bits that are writable in mie
    localparam logic [31:0] MIE_STD_MASK = 32'h0000_0888;
    localparam int          IRQ_LOCAL_BASE = 16;

    // Exception cause codes
    localparam logic [4:0] CAUSE_BREAKPOINT  = 5'd3;
    localparam logic [4:0] CAUSE_LD_MISALIGN = 5'd4;
    localparam logic [4:0] CAUSE_ST_MISALIGN = 5'd6;
    localparam logic [4:0] CAUSE_ECALL_M     = 5'd11;

    // Interrupt cause codes
    localparam logic [4:0] IRQ_MSI = 5'd3;
    localparam logic [4:0] IRQ_MTI = 5'd7;
    localparam logic [4:0] IRQ_MEI = 5'd11;

    // mtvec modes
    localparam logic [1:0] MTVEC_DIRECT   = 2'b00;
    localparam logic [1:0] MTVEC_VECTORED = 2'b01;

    typedef enum logic [1:0] {
        CSR_OP_NONE  = 2'b00,
        CSR_OP_WRITE = 2'b01,
        CSR_OP_SET   = 2'b10,
        CSR_OP_CLEAR = 2'b11
    } csr_op_e;

    // True for every address that has storage or a defined read value
    function automatic logic csr_is_implemented(input logic [11:0] addr);
        logic hit;
        case (addr)
            CSR_MSTATUS, CSR_MISA, CSR_MIE, CSR_MTVEC,
            CSR_MSCRATCH, CSR_MEPC, CSR_MCAUSE, CSR_MTVAL, CSR_MIP,
            CSR_MCYCLE, CSR_MINSTRET, CSR_MCYCLEH, CSR_MINSTRETH,
            CSR_CYCLE, CSR_INSTRET, CSR_CYCLEH, CSR_INSTRETH,
            CSR_MHARTID: hit = 1'b1;
            default:     hit = 1'b0;
        endcase
        return hit;
    endfunction

    // Read-modify-write result of a CSR operation
    function automatic logic [31:0] csr_apply_op(input csr_op_e op,
                                                 input logic [31:0] old_val,
                                                 input logic [31:0] operand);
        logic [31:0] res;
        case (op)
            CSR_OP_WRITE: res = operand;
            CSR_OP_SET:   res = old_val | operand;
            CSR_OP_CLEAR: res = old_val & ~operand;
            default:      res = old_val;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/csr_trap_unit_irq_arbiter.sv
// Fixed-priority interrupt encoder: MEI > MSI > MTI > local lines,
// lowest local index first. Inputs are already masked by mie.
module csr_trap_unit_irq_arbiter
    import csr_trap_unit_pkg::*;
#(
    parameter int NUM_LOCAL_IRQ = 16
) (
    input  logic                     mei_i,
    input  logic                     msi_i,
    input  logic                     mti_i,
    input  logic [NUM_LOCAL_IRQ-1:0] local_i,
    output logic                     pending_o,
    output logic [4:0]               code_o
);

    logic       local_hit_s;
    logic [4:0] local_code_s;

    // Lowest-numbered active local line; scanning downward lets it win last
    always_comb begin
        local_hit_s  = 1'b0;
        local_code_s = 5'd0;
        for (int i = NUM_LOCAL_IRQ - 1; i >= 0; i--) begin
            if (local_i[i]) begin
                local_hit_s  = 1'b1;
                local_code_s = 5'(IRQ_LOCAL_BASE + i);
            end else begin
                local_hit_s  = local_hit_s;
            end
        end
    end

    // Standard interrupts outrank every local line
    always_comb begin
        pending_o = 1'b1;
        code_o    = 5'd0;
        if (mei_i) begin
            code_o = IRQ_MEI;
        end else if (msi_i) begin
            code_o = IRQ_MSI;
        end else if (mti_i) begin
            code_o = IRQ_MTI;
        end else begin
            pending_o = local_hit_s;
            code_o    = local_code_s;
        end
    end

endmodule

// File: rtl/csr_trap_unit.sv
// Machine-mode CSR file with trap sequencing. Reads are combinational,
// state updates on clk. Per cycle the winning event is:
// reset > exception > interrupt > mret > CSR write.
module csr_trap_unit
    import csr_trap_unit_pkg::*;
#(
    parameter int          NUM_LOCAL_IRQ = 16,
    parameter logic [31:0] MTVEC_RST     = 32'h0000_0000,
    parameter logic [31:0] MISA_VAL      = 32'h4000_0100,
    parameter int          HART_ID       = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     r_en_i,
    input  logic                     w_en_i,
    input  logic [2:0]               op_i,
    input  logic [11:0]              csr_addr_i,
    input  logic [31:0]              wdata_i,
    output logic [31:0]              rdata_o,
    output logic                     illegal_access_o,
    input  logic [31:0]              pc_i,
    input  logic                     ecall_i,
    input  logic                     ebreak_i,
    input  logic                     misaligned_ld_i,
    input  logic                     misaligned_st_i,
    input  logic [31:0]              bad_addr_i,
    input  logic                     instr_retired_i,
    input  logic                     irq_allow_i,
    input  logic                     irq_ext_i,
    input  logic                     irq_timer_i,
    input  logic                     irq_sw_i,
    input  logic [NUM_LOCAL_IRQ-1:0] irq_local_i,
    input  logic                     mret_i,
    output logic                     trap_taken_o,
    output logic [31:0]              trap_vector_o,
    output logic [31:0]              epc_out_o
);

    localparam logic [31:0] MIE_MASK =
        MIE_STD_MASK | (((32'd1 << NUM_LOCAL_IRQ) - 32'd1) << IRQ_LOCAL_BASE);

    logic        mst_mie_q, mst_mie_d;
    logic        mst_mpie_q, mst_mpie_d;
    logic [31:0] mie_q, mie_d;
    logic [31:0] mtvec_q, mtvec_d;
    logic [31:0] mscratch_q, mscratch_d;
    logic [31:0] mepc_q, mepc_d;
    logic [31:0] mcause_q, mcause_d;
    logic [31:0] mtval_q, mtval_d;
    logic [63:0] mcycle_q, mcycle_d;
    logic [63:0] minstret_q, minstret_d;

    csr_op_e     op_s;
    logic [31:0] mip_s;
    logic [31:0] mstatus_s;
    logic [31:0] csr_value_s;
    logic [31:0] wval_s;
    logic [31:0] base_s;
    logic        impl_s;
    logic        wr_req_s;
    logic        illegal_s;
    logic        csr_wr_s;
    logic        exc_s;
    logic [4:0]  exc_code_s;
    logic [31:0] exc_tval_s;
    logic        arb_pend_s;
    logic [4:0]  irq_code_s;
    logic        irq_take_s;
    logic        trap_s;

    // Decode the operation; the top op bit carries no meaning here
    always_comb begin
        case (op_i) inside
            3'b?01:  op_s = CSR_OP_WRITE;
            3'b?10:  op_s = CSR_OP_SET;
            3'b?11:  op_s = CSR_OP_CLEAR;
            default: op_s = CSR_OP_NONE;
        endcase
    end

    // Live interrupt levels as presented through mip
    always_comb begin
        mip_s = 32'd0;
        mip_s[IRQ_MSI] = irq_sw_i;
        mip_s[IRQ_MTI] = irq_timer_i;
        mip_s[IRQ_MEI] = irq_ext_i;
        mip_s[IRQ_LOCAL_BASE +: NUM_LOCAL_IRQ] = irq_local_i;
    end

    // mstatus view: fixed MPP plus the two stored enable bits
    always_comb begin
        mstatus_s = MSTATUS_RST;
        mstatus_s[MSTATUS_MIE_BIT]  = mst_mie_q;
        mstatus_s[MSTATUS_MPIE_BIT] = mst_mpie_q;
    end

    // Current value of the addressed CSR (pre-write in a write cycle)
    always_comb begin
        case (csr_addr_i)
            CSR_MSTATUS:                  csr_value_s = mstatus_s;
            CSR_MISA:                     csr_value_s = MISA_VAL;
            CSR_MIE:                      csr_value_s = mie_q;
            CSR_MTVEC:                    csr_value_s = mtvec_q;
            CSR_MSCRATCH:                 csr_value_s = mscratch_q;
            CSR_MEPC:                     csr_value_s = mepc_q;
            CSR_MCAUSE:                   csr_value_s = mcause_q;
            CSR_MTVAL:                    csr_value_s = mtval_q;
            CSR_MIP:                      csr_value_s = mip_s;
            CSR_MCYCLE, CSR_CYCLE:        csr_value_s = mcycle_q[31:0];
            CSR_MCYCLEH, CSR_CYCLEH:      csr_value_s = mcycle_q[63:32];
            CSR_MINSTRET, CSR_INSTRET:    csr_value_s = minstret_q[31:0];
            CSR_MINSTRETH, CSR_INSTRETH:  csr_value_s = minstret_q[63:32];
            CSR_MHARTID:                  csr_value_s = 32'(HART_ID);
            default:                      csr_value_s = 32'd0;
        endcase
    end

    // Access legality and the gated write strobe
    always_comb begin
        impl_s   = csr_is_implemented(csr_addr_i);
        // set/clear with a zero mask leaves the CSR untouched: not a write
        wr_req_s = w_en_i & ((op_s == CSR_OP_WRITE) |
                   (((op_s == CSR_OP_SET) | (op_s == CSR_OP_CLEAR)) & (wdata_i != 32'd0)));
        illegal_s = ((r_en_i | w_en_i) & ~impl_s) |
                    (wr_req_s & (csr_addr_i[11:10] == 2'b11));
        csr_wr_s  = wr_req_s & ~illegal_s & ~trap_s & ~mret_i;
        wval_s    = csr_apply_op(op_s, csr_value_s, wdata_i);
    end

    // Synchronous exceptions in fixed priority order
    always_comb begin
        exc_s      = 1'b1;
        exc_code_s = 5'd0;
        exc_tval_s = 32'd0;
        if (ebreak_i) begin
            exc_code_s = CAUSE_BREAKPOINT;
            exc_tval_s = pc_i;
        end else if (ecall_i) begin
            exc_code_s = CAUSE_ECALL_M;
        end else if (misaligned_ld_i) begin
            exc_code_s = CAUSE_LD_MISALIGN;
            exc_tval_s = bad_addr_i;
        end else if (misaligned_st_i) begin
            exc_code_s = CAUSE_ST_MISALIGN;
            exc_tval_s = bad_addr_i;
        end else begin
            exc_s = 1'b0;
        end
    end

    csr_trap_unit_irq_arbiter #(
        .NUM_LOCAL_IRQ (NUM_LOCAL_IRQ)
    ) u_irq_arbiter (
        .mei_i     (irq_ext_i & mie_q[IRQ_MEI]),
        .msi_i     (irq_sw_i & mie_q[IRQ_MSI]),
        .mti_i     (irq_timer_i & mie_q[IRQ_MTI]),
        .local_i   (irq_local_i & mie_q[IRQ_LOCAL_BASE +: NUM_LOCAL_IRQ]),
        .pending_o (arb_pend_s),
        .code_o    (irq_code_s)
    );

    // Trap request and redirect target
    always_comb begin
        irq_take_s = mst_mie_q & irq_allow_i & arb_pend_s;
        trap_s     = exc_s | irq_take_s;
        base_s     = {mtvec_q[31:2], 2'b00};
        if (irq_take_s & ~exc_s & (mtvec_q[1:0] == MTVEC_VECTORED)) begin
            trap_vector_o = base_s + 32'({irq_code_s, 2'b00});
        end else begin
            trap_vector_o = base_s;
        end
    end

    // Next-state for all CSRs; counters advance unless a write claims a half
    always_comb begin
        mst_mie_d  = mst_mie_q;
        mst_mpie_d = mst_mpie_q;
        mie_d      = mie_q;
        mtvec_d    = mtvec_q;
        mscratch_d = mscratch_q;
        mepc_d     = mepc_q;
        mcause_d   = mcause_q;
        mtval_d    = mtval_q;
        mcycle_d   = mcycle_q + 64'd1;
        minstret_d = minstret_q + {63'd0, instr_retired_i};
        if (trap_s) begin
            mepc_d     = pc_i & ~32'd3;
            mcause_d   = exc_s ? {27'd0, exc_code_s} : {1'b1, 26'd0, irq_code_s};
            mtval_d    = exc_s ? exc_tval_s : 32'd0;
            mst_mpie_d = mst_mie_q;
            mst_mie_d  = 1'b0;
        end else if (mret_i) begin
            mst_mie_d  = mst_mpie_q;
            mst_mpie_d = 1'b1;
        end else if (csr_wr_s) begin
            case (csr_addr_i)
                CSR_MSTATUS: begin
                    mst_mie_d  = wval_s[MSTATUS_MIE_BIT];
                    mst_mpie_d = wval_s[MSTATUS_MPIE_BIT];
                end
                CSR_MIE:       mie_d      = wval_s & MIE_MASK;
                // reserved modes (1x) collapse to direct
                CSR_MTVEC:     mtvec_d    = {wval_s[31:2], 1'b0, wval_s[0] & ~wval_s[1]};
                CSR_MSCRATCH:  mscratch_d = wval_s;
                CSR_MEPC:      mepc_d     = {wval_s[31:2], 2'b00};
                CSR_MCAUSE:    mcause_d   = wval_s;
                CSR_MTVAL:     mtval_d    = wval_s;
                CSR_MCYCLE:    mcycle_d   = {mcycle_q[63:32], wval_s};
                CSR_MCYCLEH:   mcycle_d   = {wval_s, mcycle_q[31:0]};
                CSR_MINSTRET:  minstret_d = {minstret_q[63:32], wval_s};
                CSR_MINSTRETH: minstret_d = {wval_s, minstret_q[31:0]};
                default:       mie_d      = mie_q;
            endcase
        end else begin
            mie_d = mie_q;
        end
    end

    // CSR state registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            mst_mie_q  <= 1'b0;
            mst_mpie_q <= 1'b0;
            mie_q      <= 32'd0;
            mtvec_q    <= MTVEC_RST;
            mscratch_q <= 32'd0;
            mepc_q     <= 32'd0;
            mcause_q   <= 32'd0;
            mtval_q    <= 32'd0;
            mcycle_q   <= 64'd0;
            minstret_q <= 64'd0;
        end else begin
            mst_mie_q  <= mst_mie_d;
            mst_mpie_q <= mst_mpie_d;
            mie_q      <= mie_d;
            mtvec_q    <= mtvec_d;
            mscratch_q <= mscratch_d;
            mepc_q     <= mepc_d;
            mcause_q   <= mcause_d;
            mtval_q    <= mtval_d;
            mcycle_q   <= mcycle_d;
            minstret_q <= minstret_d;
        end
    end

    assign rdata_o          = (r_en_i & impl_s) ? csr_value_s : 32'd0;
    assign illegal_access_o = illegal_s;
    assign trap_taken_o     = trap_s & ~rst;
    assign epc_out_o        = mepc_q;

endmodule

// File: doc/csr_trap_unit.md
Name: csr_trap_unit

Overview:
Machine-mode CSR file with full trap handling. Generalised over the register-array CSR block: only architected CSRs are stored, it has 64-bit counters, and it adds prioritised interrupts, direct/vectored mtvec, mtval, and illegal-access detection. Sits beside the execute stage. The core supplies CSR ops, exception and interrupt inputs; the unit returns read data, a trap request and the redirect target.

Parameters:
NUM_LOCAL_IRQ, 16, local interrupt lines, mcause codes 16..16+N-1 (1..16).
MTVEC_RST, 32'h0000_0000, reset trap base/mode.
MISA_VAL, 32'h4000_0100, read-only misa value (RV32I).
HART_ID, 0, read-only mhartid value.

Ports:
clk  in  1  clock
rst  in  1  reset
r_en  in  1  CSR read enable
w_en  in  1  CSR write enable
op  in  3  [1:0] 01=write, 10=set, 11=clear; op[2] ignored
csr_addr  in  12  CSR address
wdata  in  32  write operand
rdata  out  32  read data
illegal_access  out  1  unimplemented address, or write to read-only
pc  in  32  PC of current instruction
ecall, ebreak, misaligned_ld, misaligned_st  in  1 each  exception requests
bad_addr  in  32  faulting memory address
instr_retired  in  1  instruction retires this cycle
irq_allow  in  1  core at an interruptible boundary
irq_ext, irq_timer, irq_sw  in  1 each  MEI/MTI/MSI, level-sensitive
irq_local  in  NUM_LOCAL_IRQ  local interrupts, level-sensitive
mret  in  1  return from trap
trap_taken  out  1  redirect to trap_vector this cycle
trap_vector  out  32  trap target
epc_out  out  32  current mepc (mret target)

Behaviour:
- Reset is synchronous and active-high on clk. All CSRs take reset values: mstatus=0x0000_1800 (MPP fixed 11), mie=0, mtvec=MTVEC_RST, other writable CSRs 0, counters 0. rdata, trap_taken, illegal_access are combinational from reset state.
- Implemented CSRs:
  - mstatus 0x300: only MIE[3] and MPIE[7] writable.
  - misa 0x301: RO.
  - mie 0x304: writable bits 3, 7, 11, 16+.
  - mtvec 0x305: mode[1:0] 00 direct, 01 vectored; 1x written as 00.
  - mscratch 0x340.
  - mepc 0x341: bits[1:0] read 0.
  - mcause 0x342, mtval 0x343.
  - mip 0x344: RO, live input levels.
  - mcycle/mcycleh 0xB00/0xB80, minstret/minstreth 0xB02/0xB82.
  - cycle/instret aliases 0xC00/0xC02/0xC80/0xC82: RO.
  - mhartid 0xF14: RO.
- Read: rdata = CSR value when r_en and the address is implemented, else 0. Zero latency. A read in the same cycle as a write returns the pre-write value.
- illegal_access = (r_en|w_en) and unimplemented address, or w_en and csr_addr[11:10]==11. An illegal write is dropped.
- Set/clear with wdata==0 is not a write: no update, no RO illegal.
- Exceptions, in priority order:
  - ebreak: cause 3, mtval=pc.
  - ecall: cause 11, mtval=0.
  - misaligned_ld: cause 4, mtval=bad_addr.
  - misaligned_st: cause 6, mtval=bad_addr.
- Interrupt pending = mstatus.MIE & irq_allow & |(mip & mie). Priority: MEI(11) > MSI(3) > MTI(7) > local (lowest index first). mcause = {1, code}; mtval=0.
- Event priority per cycle: rst > exception > interrupt > mret > CSR write. A lower-priority event in the same cycle is ignored.
- On a trap, trap_taken=1 combinationally. At the next edge: mepc<=pc, mcause, mtval set; MPIE<=MIE; MIE<=0.
- trap_vector = base for exceptions and direct mode. In vectored mode, interrupts go to base + 4*code, with base = {mtvec[31:2],2'b00}.
- mret: MIE<=MPIE, MPIE<=1. epc_out always reflects mepc.
- Counters: mcycle +1 every non-reset cycle; minstret +1 when instr_retired. Both wrap at 2^64.
- A CSR write to a counter half in the same cycle overrides that half's increment. The other half holds; no carry in that cycle.

Decomposition:
- Shared package csr_pkg.vh holds CSR addresses, reset values, cause codes, mstatus bit indices, and op encodings.
- One natural sub-module: csr_irq_arbiter (combinational priority encoder). It takes mip & mie and returns pending and code.

Test Plan:
1. Reset, then read 0x300 → 0x0000_1800; read 0x305 → MTVEC_RST; read 0x7C0 → rdata=0, illegal_access=1.
2. Write mstatus=0x8; ecall at pc=0x100 → trap_taken=1, trap_vector=base; then mepc=0x100, mcause=11, MIE=0, MPIE=1. mret → MIE=1.
3. Write mtvec=0x1001, mie=0x80, MIE=1, irq_timer=1, irq_allow=1 → trap_vector=0x101C, mcause=0x8000_0007.
4. misaligned_st with bad_addr=0x203 together with irq_ext pending → exception wins: mcause=6, mtval=0x203; the interrupt is taken after mret.
5. Write mcycle=0xFFFF_FFFF, mcycleh=0 → one cycle later mcycleh=1, mcycle=0. Write 0xC00 → illegal_access=1, value unchanged.
6. Assert rst mid-trap (ecall active) → all CSRs at reset values next cycle, trap_taken=0.
